// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: default input count,
// FSM state encoding and table-width helper.
package truth_table_sweeper_pkg;

    localparam int N_IN_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_sweep_counter.sv
// Vector index counter with terminal flag, plus the settle-time counter
// that holds each vector for SETTLE cycles while the FSM is in DRIVE.
import truth_table_sweeper_pkg::*;

module sweep_counter #(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            drive,
    input  logic            clr,
    input  logic            inc,
    output logic [N_IN-1:0] idx,
    output logic            idx_last,
    output logic            settle_done
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [N_IN-1:0] idx_q, idx_d;
    logic [SW-1:0]   settle_q, settle_d;

    assign idx         = idx_q;
    assign idx_last    = &idx_q;
    assign settle_done = drive && (settle_q == SW'(SETTLE - 1));

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        idx_d    = idx_q;
        settle_d = '0;
        if (clr) begin
            idx_d = '0;
        end else if (inc) begin
            idx_d = idx_q + 1'b1;
        end
        // Counts elapsed DRIVE cycles; cleared whenever the vector is not being held.
        if (drive && !settle_done) begin
            settle_d = settle_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            settle_q <= '0;
        end else begin
            idx_q    <= idx_d;
            settle_q <= settle_d;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives a combinational block through every input vector, captures its
// output into a truth table and compares it against a latched golden table.
import truth_table_sweeper_pkg::*;

module truth_table_sweeper #(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [tt_width(N_IN)-1:0] expected,
    input  logic                      y_i,
    output logic [N_IN-1:0]           abcd_o,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [tt_width(N_IN)-1:0] table_o,
    output logic [N_IN:0]             mismatch_cnt,
    output logic [N_IN-1:0]           first_fail,
    output logic                      fail_valid
);

    localparam int            TT_W    = tt_width(N_IN);
    localparam logic [N_IN:0] CNT_ONE = 1;

    state_e          state_q, state_d;
    logic [TT_W-1:0] exp_q, exp_d;
    logic [TT_W-1:0] table_q, table_d;
    logic [N_IN:0]   mcnt_q, mcnt_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            fv_q, fv_d;
    logic            pass_q, pass_d;

    logic            idx_clr, idx_inc;
    logic [N_IN-1:0] idx;
    logic            idx_last, settle_done;

    sweep_counter #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .drive       (state_q == ST_DRIVE),
        .clr         (idx_clr),
        .inc         (idx_inc),
        .idx         (idx),
        .idx_last    (idx_last),
        .settle_done (settle_done)
    );

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        table_d = table_q;
        mcnt_d  = mcnt_q;
        ff_d    = ff_q;
        fv_d    = fv_q;
        pass_d  = pass_q;
        idx_clr = 1'b0;
        idx_inc = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        abcd_o  = '0;

        case (state_q)
            ST_IDLE: begin
                // abort has priority over a simultaneous start.
                if (start && !abort) begin
                    exp_d   = expected;
                    table_d = '0;
                    mcnt_d  = '0;
                    ff_d    = '0;
                    fv_d    = 1'b0;
                    pass_d  = 1'b0;
                    idx_clr = 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                busy   = 1'b1;
                abcd_o = idx;
                if (abort) begin
                    pass_d  = 1'b0;
                    fv_d    = 1'b0;
                    state_d = ST_IDLE;
                end else if (settle_done) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                busy   = 1'b1;
                abcd_o = idx;
                if (abort) begin
                    pass_d  = 1'b0;
                    fv_d    = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    table_d[idx] = y_i;
                    if (y_i != exp_q[idx]) begin
                        mcnt_d = mcnt_q + CNT_ONE;
                        if (!fv_q) begin
                            ff_d = idx;
                            fv_d = 1'b1;
                        end
                    end
                    if (idx_last) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_inc = 1'b1;
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_FINISH: begin
                done    = 1'b1;
                pass_d  = (mcnt_q == '0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the golden-table copy is a plain register bank, so it is reset like the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            exp_q   <= '0;
            table_q <= '0;
            mcnt_q  <= '0;
            ff_q    <= '0;
            fv_q    <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            table_q <= table_d;
            mcnt_q  <= mcnt_d;
            ff_q    <= ff_d;
            fv_q    <= fv_d;
            pass_q  <= pass_d;
        end
    end

    assign table_o      = table_q;
    assign mismatch_cnt = mcnt_q;
    assign first_fail   = ff_q;
    assign fail_valid   = fv_q;
    assign pass         = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: expected sweep results are queued at start and compared
// when done pulses; covers latency, restart/abort/reset corner cases, SETTLE=3.
module tb_truth_table_sweeper;

    typedef struct {
        logic [15:0] tbl;
        logic [4:0]  cnt;
        logic [3:0]  ff;
        logic        fv;
        logic        pass;
    } result_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] expected = 16'h0000;
    bit          sel = 1'b0;
    int          mode = 0;

    int checks = 0;
    int errors = 0;
    result_t sb[$];

    logic        start1, start3, abort1, abort3, y1, y3;
    logic [3:0]  abcd1, abcd3, ff1, ff3;
    logic        busy1, busy3, done1, done3, pass1, pass3, fv1, fv3;
    logic [15:0] tbl1, tbl3;
    logic [4:0]  cnt1, cnt3;

    assign start1 = start & ~sel;
    assign start3 = start & sel;
    assign abort1 = abort & ~sel;
    assign abort3 = abort & sel;

    function automatic logic model_y(input logic [3:0] v, input int m);
        logic p;
        p = ^v;
        case (m)
            1:       return (v == 4'd5) ? ~p : p;
            2:       return 1'b0;
            default: return p;
        endcase
    endfunction

    always_comb y1 = model_y(abcd1, mode);
    always_comb y3 = model_y(abcd3, mode);

    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .expected(expected), .y_i(y1), .abcd_o(abcd1), .busy(busy1),
        .done(done1), .pass(pass1), .table_o(tbl1), .mismatch_cnt(cnt1),
        .first_fail(ff1), .fail_valid(fv1)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .expected(expected), .y_i(y3), .abcd_o(abcd3), .busy(busy3),
        .done(done3), .pass(pass3), .table_o(tbl3), .mismatch_cnt(cnt3),
        .first_fail(ff3), .fail_valid(fv3)
    );

    wire [3:0]  abcd_m = sel ? abcd3 : abcd1;
    wire        busy_m = sel ? busy3 : busy1;
    wire        done_m = sel ? done3 : done1;
    wire        pass_m = sel ? pass3 : pass1;
    wire        fv_m   = sel ? fv3   : fv1;
    wire [3:0]  ff_m   = sel ? ff3   : ff1;
    wire [15:0] tbl_m  = sel ? tbl3  : tbl1;
    wire [4:0]  cnt_m  = sel ? cnt3  : cnt1;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic result_t model_result(input logic [15:0] exp_tbl, input int m);
        result_t r;
        r.tbl = '0; r.cnt = '0; r.ff = '0; r.fv = 1'b0;
        for (int i = 0; i < 16; i++) begin
            r.tbl[i] = model_y(4'(i), m);
            if (r.tbl[i] != exp_tbl[i]) begin
                r.cnt++;
                if (!r.fv) begin
                    r.ff = 4'(i);
                    r.fv = 1'b1;
                end
            end
        end
        r.pass = (r.cnt == 0);
        return r;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy_m, 0);
        check({tag, "_done"}, done_m, 0);
        check({tag, "_abcd"}, abcd_m, 0);
        check({tag, "_table"}, tbl_m, 0);
        check({tag, "_cnt"}, cnt_m, 0);
        check({tag, "_pass"}, pass_m, 0);
        check({tag, "_fv"}, fv_m, 0);
        check({tag, "_ff"}, ff_m, 0);
    endtask

    task automatic run_sweep(input logic [15:0] exp_tbl, input int settle,
                             input bit repulse, input bit exp_change);
        result_t r;
        int n, hold;
        logic [3:0] prev;
        sb.push_back(model_result(exp_tbl, mode));
        expected = exp_tbl;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 1;
        hold = 0;
        prev = '0;
        check("busy_after_start", busy_m, 1);
        check("first_vector", abcd_m, 0);
        while (!done_m && n < 200) begin
            if (repulse && n == 10) start = 1'b1;
            if (repulse && n == 11) start = 1'b0;
            if (exp_change && n == 5) expected = ~exp_tbl;
            if (busy_m) begin
                if (n == 1) begin
                    prev = abcd_m;
                    hold = 1;
                end else if (abcd_m == prev) begin
                    hold++;
                end else begin
                    check("vector_hold", hold, settle + 1);
                    check("vector_step", abcd_m, prev + 4'd1);
                    prev = abcd_m;
                    hold = 1;
                end
            end
            @(negedge clk);
            n++;
        end
        check("last_vector_hold", hold, settle + 1);
        check("last_vector", prev, 15);
        check("done_latency", n, 16 * (settle + 1) + 1);
        check("busy_at_done", busy_m, 0);
        r = sb.pop_front();
        check("table_o", tbl_m, r.tbl);
        check("mismatch_cnt", cnt_m, r.cnt);
        check("fail_valid", fv_m, r.fv);
        if (r.fv) check("first_fail", ff_m, r.ff);
        @(negedge clk);
        check("pass", pass_m, r.pass);
        check("done_one_cycle", done_m, 0);
        check("idle_abcd", abcd_m, 0);
        expected = exp_tbl;
    endtask

    initial begin
        int n, dcount;

        #12;
        check_outputs_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // Parity function, clean table.
        mode = 0;
        run_sweep(16'h6996, 1, 1'b0, 1'b0);

        // Fault at index 5, with start re-pulsed and golden table altered mid-sweep.
        mode = 1;
        run_sweep(16'h6996, 1, 1'b1, 1'b1);

        // Output stuck at 0 against an all-ones table.
        mode = 2;
        run_sweep(16'hFFFF, 1, 1'b0, 1'b0);

        // start and abort together in IDLE.
        mode = 0;
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        check("start_abort_idle_busy", busy_m, 0);
        repeat (3) @(negedge clk);
        check("start_abort_idle_still", busy_m, 0);

        // Abort once idx reaches 7 (fault at 5 has already been recorded).
        mode = 1;
        expected = 16'h6996;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (abcd_m != 4'd7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_idx7", abcd_m, 7);
        check("abort_fv_before", fv_m, 1);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("abort_busy", busy_m, 0);
        check("abort_abcd", abcd_m, 0);
        check("abort_pass", pass_m, 0);
        check("abort_fv", fv_m, 0);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_m) dcount++;
        end
        check("abort_no_done", dcount, 0);

        // Asynchronous reset in mid-sweep at idx 9.
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (abcd_m != 4'd9 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reset_reached_idx9", abcd_m, 9);
        check("reset_table_nonzero", (tbl_m != 16'h0), 1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // SETTLE=3 instance: four cycles per vector, done at +65.
        sel = 1'b1;
        mode = 1;
        run_sweep(16'h6996, 3, 1'b0, 1'b0);
        mode = 0;
        run_sweep(16'h6996, 3, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
